// File: rtl/wb_master_if_if.sv
// Bundle of the local command/response ports and the Wishbone classic master bus.
// master modport: the initiator (wb_master_if); slave modport: local logic + Wishbone slave side.
// Ports: cmd_* (valid/ready command in), rsp_* (valid/ready response out), Wishbone ADR/DAT/WE/STB/CYC/ACK.
interface wb_master_if_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic        ACK_I;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, DAT_I, ACK_I,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, ADR_O, DAT_O, WE_O, STB_O, CYC_O
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, DAT_I, ACK_I,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, ADR_O, DAT_O, WE_O, STB_O, CYC_O
  );
endinterface

// File: rtl/wb_master_if.sv
// Wishbone classic single-transfer initiator with a CMD_DEPTH-entry command FIFO.
// Latency: push -> STB_O on the second edge; ACK_I sampled -> rsp_valid on the next edge.
// Backpressure: cmd_ready = !full; a held response (rsp_ready=0) blocks new bus cycles.
// Ports: CLK_I, RST_I (async, active-high), bus (wb_master_if_if.master: cmd_*, rsp_*, Wishbone).
module wb_master_if #(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  wb_master_if_if.master bus
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = $clog2(TIMEOUT);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  // Command FIFO
  cmd_t          mem [CMD_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  cmd_t          head;
  cmd_t          wr_entry;

  // FSM and registered outputs
  state_t        state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          rvld_q, rvld_d;
  logic          err_q, err_d;

  assign full     = (count == (AW+1)'(CMD_DEPTH));
  assign empty    = (count == '0);
  // A full FIFO refuses the push even when the FSM pops in the same cycle.
  assign push     = bus.cmd_valid && !full;
  assign head     = mem[rd_ptr];
  assign wr_entry = '{we: bus.cmd_we, addr: bus.cmd_addr, wdata: bus.cmd_wdata};

  always_ff @(posedge CLK_I) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      rvld_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      rvld_q  <= rvld_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    rvld_d  = rvld_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        // A slave that still holds ACK_I from the last transfer must release
        // it first, otherwise the stale ACK would complete the new cycle.
        if (!empty && !bus.ACK_I) begin
          pop     = 1'b1;
          adr_d   = head.addr;
          dat_d   = head.wdata;
          we_d    = head.we;
          cyc_d   = 1'b1;
          tmo_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        tmo_d = tmo_q + CW'(1);
        // ACK is checked first so it wins over a coincident timeout.
        if (bus.ACK_I) begin
          cyc_d   = 1'b0;
          rvld_d  = 1'b1;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : bus.DAT_I;
          state_d = RESP;
        end else if (tmo_q == CW'(TIMEOUT - 1)) begin
          cyc_d   = 1'b0;
          rvld_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rvld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = !full;
  assign bus.ADR_O     = adr_q;
  assign bus.DAT_O     = dat_q;
  assign bus.WE_O      = we_q;
  // STB_O and CYC_O are identical for single classic transfers.
  assign bus.CYC_O     = cyc_q;
  assign bus.STB_O     = cyc_q;
  assign bus.rsp_valid = rvld_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_wb_master_if.sv
module tb_wb_master_if;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  wb_master_if_if bus();

  wb_master_if #(.CMD_DEPTH(4), .TIMEOUT(64)) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Wishbone slave model knobs
  int          ack_delay = 1;
  int          ack_extra = 0;
  bit          ack_never = 1'b0;
  bit          use_adr   = 1'b0;
  logic [31:0] slave_rdata = '0;
  int          wcnt, hcnt;

  // Slave: raises ACK_I after STB_O has been seen ack_delay times, keeps it
  // for 1+ack_extra sampling edges. Drives on negedge.
  initial begin
    bus.ACK_I = 1'b0;
    bus.DAT_I = '0;
    wcnt = 0;
    hcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.ACK_I = 1'b0;
        wcnt = 0;
        hcnt = 0;
      end else if (hcnt > 0) begin
        hcnt--;
        if (hcnt == 0) bus.ACK_I = 1'b0;
      end else if (bus.STB_O && !ack_never) begin
        wcnt++;
        if (wcnt >= ack_delay) begin
          bus.ACK_I = 1'b1;
          bus.DAT_I = use_adr ? (bus.ADR_O ^ 32'h5A5A_0000) : slave_rdata;
          hcnt = 1 + ack_extra;
          wcnt = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_stb(input string name);
    int n = 0;
    while (!bus.STB_O && n < 300) begin tick(); n++; end
    chk(name, bus.STB_O, 1);
  endtask

  task automatic wait_rsp(input string name, output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 300) begin tick(); lat++; end
    chk(name, bus.rsp_valid, 1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dat_i;
    int          delay;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vt [7];
  logic [31:0] fa [5];
  logic        fwe [5];
  int          lat, t0, nq, n;
  bit          stable, bp_ok, acc;

  initial begin
    vt[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3, 3, 32'h0, 1'b0};
    vt[1] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678, 1, 1, 32'h1234_5678, 1'b0};
    vt[2] = '{1'b0, 32'h0000_0024, 32'h1111_2222, 32'hA5A5_A5A5, 5, 5, 32'hA5A5_A5A5, 1'b0};
    vt[3] = '{1'b1, 32'h0000_0030, 32'hCAFE_F00D, 32'h0000_0055, 2, 2, 32'h0, 1'b0};
    vt[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1, 1, 32'h0, 1'b0};
    vt[5] = '{1'b0, 32'h0000_0060, 32'h0000_0000, 32'h600D_600D, 64, 64, 32'h600D_600D, 1'b0};
    vt[6] = '{1'b0, 32'h0000_0064, 32'h0000_0000, 32'h7777_7777, 65, 64, 32'h0, 1'b1};

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_stb", bus.STB_O, 0);
    chk("rst_cyc", bus.CYC_O, 0);
    chk("rst_adr", bus.ADR_O, 0);
    chk("rst_we", bus.WE_O, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    rst = 1'b0;
    tick();

    // Single transfers from an empty FIFO
    for (int i = 0; i < 7; i++) begin
      slave_rdata = vt[i].dat_i;
      ack_delay   = vt[i].delay;
      ack_extra   = 0;
      bus.cmd_we    = vt[i].we;
      bus.cmd_addr  = vt[i].addr;
      bus.cmd_wdata = vt[i].wdata;
      bus.cmd_valid = 1'b1;
      chk($sformatf("v%0d_cmd_ready", i), bus.cmd_ready, 1);
      tick();
      bus.cmd_valid = 1'b0;
      chk($sformatf("v%0d_stb_edge1", i), bus.STB_O, 0);
      tick();
      chk($sformatf("v%0d_stb_edge2", i), bus.STB_O, 1);
      chk($sformatf("v%0d_cyc", i), bus.CYC_O, 1);
      chk($sformatf("v%0d_adr", i), bus.ADR_O, vt[i].addr);
      chk($sformatf("v%0d_dat", i), bus.DAT_O, vt[i].wdata);
      chk($sformatf("v%0d_we", i), bus.WE_O, vt[i].we);
      stable = 1'b1;
      lat = 0;
      while (!bus.rsp_valid && lat < 300) begin
        if (bus.STB_O !== 1'b1 || bus.CYC_O !== 1'b1 || bus.ADR_O !== vt[i].addr ||
            bus.DAT_O !== vt[i].wdata || bus.WE_O !== vt[i].we) stable = 1'b0;
        tick();
        lat++;
      end
      chk($sformatf("v%0d_bus_stable", i), stable, 1);
      chk($sformatf("v%0d_rsp_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_rdata", i), bus.rsp_rdata, vt[i].exp_rdata);
      chk($sformatf("v%0d_err", i), bus.rsp_err, vt[i].exp_err);
      chk($sformatf("v%0d_cyc_dropped", i), bus.CYC_O, 0);
      tick();
      chk($sformatf("v%0d_rsp_handshake", i), bus.rsp_valid, 0);
    end

    // Full FIFO and timeout of the first command
    ack_never = 1'b1;
    use_adr   = 1'b1;
    ack_delay = 1;
    fa[0] = 32'h100; fa[1] = 32'h104; fa[2] = 32'h108; fa[3] = 32'h10C; fa[4] = 32'h110;
    fwe[0] = 1'b0; fwe[1] = 1'b1; fwe[2] = 1'b0; fwe[3] = 1'b0; fwe[4] = 1'b1;
    t0 = 0;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_we    = fwe[i];
      bus.cmd_addr  = fa[i];
      bus.cmd_wdata = 32'hD000_0000 | i;
      bus.cmd_valid = 1'b1;
      chk($sformatf("full_ready_%0d", i), bus.cmd_ready, 1);
      tick();
      if (i == 1) begin
        chk("full_stb_cmd1", bus.STB_O, 1);
        t0 = cyc;
      end
    end
    bus.cmd_addr = 32'h200;
    chk("full_ready_low", bus.cmd_ready, 0);
    tick();
    tick();
    tick();
    bus.cmd_valid = 1'b0;
    chk("full_ready_still_low", bus.cmd_ready, 0);
    wait_rsp("full_tmo_wait", lat);
    chk("full_tmo_cycles", cyc - t0, 64);
    chk("full_tmo_err", bus.rsp_err, 1);
    chk("full_tmo_rdata", bus.rsp_rdata, 0);
    ack_never = 1'b0;
    tick();
    for (int k = 1; k < 5; k++) begin
      wait_stb($sformatf("full_stb_wait_%0d", k));
      chk($sformatf("full_order_adr_%0d", k), bus.ADR_O, fa[k]);
      chk($sformatf("full_order_we_%0d", k), bus.WE_O, fwe[k]);
      wait_rsp($sformatf("full_rsp_wait_%0d", k), lat);
      chk($sformatf("full_rdata_%0d", k), bus.rsp_rdata, fwe[k] ? 32'h0 : (fa[k] ^ 32'h5A5A_0000));
      chk($sformatf("full_err_%0d", k), bus.rsp_err, 0);
      tick();
    end
    for (int k = 0; k < 5; k++) tick();
    chk("full_drained_no_stb", bus.STB_O, 0);
    chk("full_drained_ready", bus.cmd_ready, 1);

    // Sticky ACK_I: second command waits for ACK_I to be sampled low
    use_adr     = 1'b0;
    slave_rdata = 32'h1357_2468;
    ack_delay   = 1;
    ack_extra   = 4;
    bus.cmd_we = 1'b0; bus.cmd_addr = 32'h300; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_addr = 32'h304;
    tick();
    bus.cmd_valid = 1'b0;
    wait_rsp("sticky_rsp1_wait", lat);
    chk("sticky_rdata1", bus.rsp_rdata, 32'h1357_2468);
    n = 0;
    while (bus.ACK_I && n < 50) begin tick(); n++; end
    chk("sticky_ack_low", bus.ACK_I, 0);
    chk("sticky_no_stb", bus.STB_O, 0);
    tick();
    chk("sticky_stb_after_low", bus.STB_O, 1);
    chk("sticky_adr2", bus.ADR_O, 32'h304);
    ack_extra = 0;
    wait_rsp("sticky_rsp2_wait", lat);
    chk("sticky_err2", bus.rsp_err, 0);
    for (int k = 0; k < 8; k++) tick();

    // Response backpressure
    bus.rsp_ready = 1'b0;
    slave_rdata   = 32'h0BAD_F00D;
    bus.cmd_we = 1'b0; bus.cmd_addr = 32'h400; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    wait_rsp("bp_rsp_wait", lat);
    nq = 0;
    bp_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = 32'h500 + 32'(4 * nq);
      acc = bus.cmd_ready;
      tick();
      if (acc) nq++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0BAD_F00D ||
          bus.rsp_err !== 1'b0 || bus.STB_O !== 1'b0) bp_ok = 1'b0;
    end
    bus.cmd_valid = 1'b0;
    chk("bp_rsp_held", bp_ok, 1);
    chk("bp_queued", nq, 4);
    chk("bp_ready_low", bus.cmd_ready, 0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_released", bus.rsp_valid, 0);
    for (int k = 0; k < 4; k++) begin
      wait_stb($sformatf("bp_stb_wait_%0d", k));
      chk($sformatf("bp_adr_%0d", k), bus.ADR_O, 32'h500 + 32'(4 * k));
      wait_rsp($sformatf("bp_rsp_wait_%0d", k), lat);
      chk($sformatf("bp_rdata_%0d", k), bus.rsp_rdata, 32'h0BAD_F00D);
      tick();
    end

    // Reset in the middle of a bus cycle
    ack_never = 1'b1;
    bus.cmd_we = 1'b1; bus.cmd_addr = 32'h600; bus.cmd_wdata = 32'h6666_0000; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_addr = 32'h604;
    tick();
    bus.cmd_valid = 1'b0;
    wait_stb("rstbus_stb_wait");
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rstbus_cyc", bus.CYC_O, 0);
    chk("rstbus_stb", bus.STB_O, 0);
    chk("rstbus_rsp_valid", bus.rsp_valid, 0);
    chk("rstbus_cmd_ready", bus.cmd_ready, 1);
    chk("rstbus_adr", bus.ADR_O, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("rstbus_fifo_empty", bus.STB_O, 0);
    chk("rstbus_ready_after", bus.cmd_ready, 1);
    ack_never = 1'b0;
    bus.cmd_we = 1'b1; bus.cmd_addr = 32'h700; bus.cmd_wdata = 32'h7070_7070; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    wait_stb("post_rst_stb_wait");
    chk("post_rst_adr", bus.ADR_O, 32'h700);
    wait_rsp("post_rst_rsp_wait", lat);
    chk("post_rst_err", bus.rsp_err, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
